// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer: issues aligned loads/stores as one access and
// splits misaligned word accesses into four little-endian byte beats.
package mem_access_sequencer_pkg;
  typedef enum logic {Word = 1'b0, Byte = 1'b1} byte_format;
endpackage

module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int DATA_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  byte_format        req_fmt,
  input  logic              req_sign,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output byte_format        mem_bytesel,
  output logic              mem_sign,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, SINGLE, SPLIT, RESP} state_t;

  state_t            state, stateNext;
  logic [1:0]        beat, beatNext;
  logic              accept;
  logic              misaligned;
  logic              err;
  logic [DATA_W-1:0] memAHold;

  logic              weQ;
  byte_format        fmtQ;
  logic              signQ;
  logic [DATA_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] result;

  assign misaligned = (req_fmt == Word) && (req_addr[1:0] != 2'b00);

  always_comb begin
    stateNext   = state;
    beatNext    = beat;
    accept      = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    mem_we      = 1'b0;
    mem_a       = memAHold;
    mem_wd      = '0;
    mem_bytesel = Word;
    mem_sign    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          beatNext = 2'd0;
          if (!misaligned)           stateNext = SINGLE;
          else if (SPLIT_MISALIGNED) stateNext = SPLIT;
          else                       stateNext = RESP;
        end
      end
      SINGLE: begin
        mem_a       = addrQ;
        mem_wd      = wdataQ;
        mem_bytesel = fmtQ;
        mem_sign    = (fmtQ == Byte) && signQ;
        mem_we      = weQ;
        stateNext   = RESP;
      end
      SPLIT: begin
        // Beat b touches byte addr+b; the address wraps naturally at the top of the map.
        mem_a       = addrQ + DATA_W'(beat);
        mem_wd      = {{(DATA_W-8){1'b0}}, wdataQ[8*beat +: 8]};
        mem_bytesel = Byte;
        mem_we      = weQ;
        beatNext    = beat + 2'd1;
        if (beat == 2'd3) stateNext = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err;
        rsp_rdata = (weQ || err) ? '0 : result;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Control state: reset aborts any in-flight request without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= 2'd0;
      err      <= 1'b0;
      memAHold <= '0;
    end else begin
      state <= stateNext;
      beat  <= beatNext;
      if (accept) err <= misaligned && !SPLIT_MISALIGNED;
      if (state == SINGLE || state == SPLIT) memAHold <= mem_a;
    end
  end

  // Request capture and load assembly.
  always_ff @(posedge clk) begin
    if (accept) begin
      weQ    <= req_we;
      fmtQ   <= req_fmt;
      signQ  <= req_sign;
      addrQ  <= req_addr;
      wdataQ <= req_wdata;
      result <= '0;
    end else if (state == SINGLE && !weQ) begin
      result <= mem_rd;
    end else if (state == SPLIT && !weQ) begin
      result[8*beat +: 8] <= mem_rd[7:0];
    end
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Requester-side initiator for the data memory port (address, write data, write enable, byte select, sign extend, read data).
- Takes load/store requests from the pipeline over a valid/ready handshake and issues aligned accesses directly as one memory access.
- Splits misaligned word accesses into four sequential byte accesses. For loads it assembles the read data; for every request it returns a one-cycle response.
- Sits between the execute/memory stage and the data memory.

Parameters:
- SPLIT_MISALIGNED, 1, 1 = split misaligned word accesses into byte beats; 0 = reject them with rsp_err and perform no memory access.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request
- req_we  in  1  1 = store, 0 = load
- req_fmt  in  byte_format  Word or Byte
- req_sign  in  1  sign-extend a Byte load
- req_addr  in  DATA_BUS  byte address
- req_wdata  in  DATA_BUS  store data; Byte uses [7:0]
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  misaligned rejected; valid with rsp_valid
- rsp_rdata  out  DATA_BUS  load result; 0 for stores and errors
- mem_we  out  1  memory write enable
- mem_a  out  DATA_BUS  memory address
- mem_wd  out  DATA_BUS  memory write data
- mem_bytesel  out  byte_format  memory byte select
- mem_sign  out  1  memory sign extend
- mem_rd  in  DATA_BUS  memory read data, combinational from mem_a

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_we=0; mem_a=0; mem_wd=0; mem_bytesel=Word; mem_sign=0; beat counter=0.
- Accept: a request is accepted on the rising edge where req_valid && req_ready. All request fields are latched at acceptance. req_ready=1 only in IDLE.
- Misaligned: req_fmt==Word && req_addr[1:0]!=0. Byte accesses are never misaligned.
- States:
  - IDLE → SINGLE on accepting an aligned or Byte request.
  - IDLE → SPLIT on accepting a misaligned request when SPLIT_MISALIGNED=1.
  - IDLE → RESP on accepting a misaligned request when SPLIT_MISALIGNED=0; err flag set, no memory access.
  - SINGLE (1 cycle): mem_a=addr, mem_wd=wdata, mem_bytesel=fmt, mem_sign=(fmt==Byte)&&sign, mem_we=we. For loads, mem_rd is captured into the result register. → RESP.
  - SPLIT (4 cycles, beat b=0..3): mem_a=addr+b (mod 2^32, wraps past 0xFFFFFFFF), mem_bytesel=Byte, mem_sign=0, mem_wd={24'b0, wdata[8b+7:8b]}, mem_we=we. Loads capture result[8b+7:8b]=mem_rd[7:0]. Ordering is little-endian. After b=3 → RESP.
  - RESP (1 cycle): rsp_valid=1; rsp_rdata=result for loads, 0 otherwise; rsp_err=err. → IDLE.
- Outside SINGLE/SPLIT: mem_we=0, mem_bytesel=Word, mem_sign=0, mem_a holds its last value, mem_wd=0.
- Latency from the accept edge:
  - Aligned/Byte: memory access in the next cycle, rsp_valid the cycle after (2 cycles).
  - Misaligned split: 4 access cycles, rsp_valid in cycle 5.
  - Rejected: rsp_valid in the next cycle.
- Throughput: the next request is accepted in the cycle after RESP, since req_ready returns with IDLE. No request overlap.
- There is no rsp_ready. The consumer must take the response in its rsp_valid cycle.
- Reset mid-operation: on the next edge the sequencer returns to IDLE with mem_we=0. Store beats already written stay in memory (no rollback). No response is issued for the aborted request.
- Registers: result and err clear on each accept. rsp_rdata is 0 whenever rsp_valid=0.

Test Plan:
- Aligned word: memory word 0x10 = 0x12345678, load Word @0x10 → single access, rsp_valid 2 cycles after accept, rsp_rdata=0x12345678, rsp_err=0.
- Byte load: word @0x20 = 0x80000000, load Byte @0x23 with sign=1 → rsp_rdata=0xFFFFFF80; with sign=0 → 0x00000080.
- Misaligned store: store Word 0xDDCCBBAA @0x01 → four write beats at mem_a 0x01..0x04, mem_bytesel=Byte, bytes AA,BB,CC,DD; memory word 0x00 = 0xCCBBAAxx (byte 0 unchanged), byte 0x04=DD; rsp_valid in cycle 5.
- Misaligned load: load Word @0x01 after the store above → 4 read beats, rsp_rdata=0xDDCCBBAA; wrap case: load @0xFFFFFFFE → beats at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Reset during SPLIT after beat 1 of store 0x44332211 @0x05 → only bytes 0x05=11 and 0x06=22 written, no rsp_valid, req_ready=1 and mem_we=0 after the reset edge.
- SPLIT_MISALIGNED=0: load Word @0x02 → mem_we stays 0 and no memory beats issued, rsp_valid with rsp_err=1 and rsp_rdata=0 one cycle after accept. Back-to-back req_valid held high → next request accepted the cycle after RESP.
